// File: rtl/gates_tester_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gates_tester_pkg
// Description : Shared definitions for the AND/OR gate tester: FSM state
//               encoding, number of test vectors, and the golden AND/OR
//               result function used to build expected responses.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package gates_tester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int NUM_VECTORS = 4;

    // Golden response of a two-input gate unit, packed as {or, and}.
    function automatic logic [1:0] exp_and_or(input logic a_in, input logic b_in);
        return {a_in | b_in, a_in & b_in};
    endfunction

endpackage : gates_tester_pkg
`default_nettype wire

// File: rtl/gates_tester_ref_model.sv
`default_nettype none
// ============================================================================
// Module      : gates_ref_model
// Description : Purely combinational expected-value generator for the gate
//               unit under test.
// Ports       : a_i, b_i        - operands currently driven to the unit
//               exp_s0_o        - expected AND result
//               exp_s1_o        - expected OR result
// Revision    : 1.0 - initial release
// ============================================================================
module gates_ref_model
    import gates_tester_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    output logic exp_s0_o,
    output logic exp_s1_o
);

    logic [1:0] exp_w;

    assign exp_w    = exp_and_or(a_i, b_i);
    assign exp_s0_o = exp_w[0];
    assign exp_s1_o = exp_w[1];

endmodule : gates_ref_model
`default_nettype wire

// File: rtl/gates_tester.sv
`default_nettype none
// ============================================================================
// Module      : gates_tester
// Description : Exhaustive tester for a two-input AND/OR gate unit. Drives
//               the four operand vectors 00,01,10,11 in order, holds each for
//               SETTLE_CYCLES cycles, samples the unit's results for one
//               cycle and accumulates a mismatch count and per-vector flags.
// Ports       : clk, rst_n (async, active-low), start (run request)
//               a, b       - registered operands to the unit under test
//               s0, s1     - AND / OR results returned by the unit
//               busy, done, pass, err_count[2:0], fail_vec[3:0] - status
// Revision    : 1.0 - initial release
// ============================================================================
module gates_tester
    import gates_tester_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       s0,
    input  logic       s1,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_IDX    = 2'(NUM_VECTORS - 1);
    localparam logic [2:0] ERR_MAX     = 3'(NUM_VECTORS);

    state_e     state_q, state_d;
    logic [1:0] idx_q,   idx_d;
    logic       a_q,     a_d;
    logic       b_q,     b_d;
    logic [2:0] err_q,   err_d;
    logic [3:0] fail_q,  fail_d;
    logic [3:0] cnt_q,   cnt_d;

    logic       exp_s0;
    logic       exp_s1;
    logic       mismatch;
    logic [1:0] idx_next;

    // Expected results are derived from the operands actually being driven,
    // so the comparison in SAMPLE always matches what the unit sees.
    gates_ref_model u_ref (
        .a_i      (a_q),
        .b_i      (b_q),
        .exp_s0_o (exp_s0),
        .exp_s1_o (exp_s1)
    );

    assign mismatch = (s0 != exp_s0) || (s1 != exp_s1);
    assign idx_next = idx_q + 2'd1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        fail_d  = fail_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // Results from the last run stay visible until a new start.
                if (start) begin
                    state_d = ST_DRIVE;
                    idx_d   = 2'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    err_d   = 3'd0;
                    fail_d  = 4'd0;
                    cnt_d   = 4'd0;
                end
            end

            ST_DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_SAMPLE: begin
                if (mismatch) begin
                    fail_d[idx_q] = 1'b1;
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + 3'd1;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                end else begin
                    // Vector index doubles as the {a,b} operand pair.
                    state_d    = ST_DRIVE;
                    idx_d      = idx_next;
                    {a_d, b_d} = idx_next;
                    cnt_d      = 4'd0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            cnt_q   <= cnt_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign busy      = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (err_q == 3'd0);
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule : gates_tester
`default_nettype wire
